pll_dyn_cfg_ctrl: RTL and testbench
===================================

Name: pll_dyn_cfg_ctrl

Overview:
- Sequencer for a GTP_PLL_E1 wrapper built with dynamic ratio/duty/phase enabled. Runs on the free-running reference clock.
- Accepts a full PLL configuration over a valid/ready handshake, then applies it safely: gates outputs off, drives the dynamic ports, pulses PLL reset, qualifies lock, and re-enables the outputs.
- Handles lock timeout with bounded retries, and reports done/error.
- Sits between HDMI mode-select logic and the PLL wrapper.

Parameters:
- NUM_OUT, 5, number of output channels driven (1..5)
- RATIO_W, 10, width of ratio and duty fields
- PHASE_W, 13, width of phase fields ({CPHASE[9:0],PHASE[2:0]})
- DEF_IDIV, 2, input divider applied after reset
- DEF_FDIV, 32, feedback divider applied after reset
- DEF_ODIV, 8, output divider (and duty) applied to every channel after reset
- DEF_PHASE, 16, phase applied to every channel after reset
- GATE_CYCLES, 4, cycles outputs stay gated before PLL reset
- RST_CYCLES, 64, PLL reset pulse length in cycles
- LOCK_STABLE, 1024, consecutive lock-high cycles needed to qualify lock
- LOCK_TIMEOUT, 100000, cycles allowed per lock attempt
- MAX_RETRY, 3, lock attempts before FAULT

Ports:
- clkin1  in  1  reference clock; all logic is in this domain
- rst  in  1  synchronous active-high reset
- cfg_valid  in  1  configuration request
- cfg_ready  out  1  controller idle and able to accept a request
- cfg_idiv  in  RATIO_W  requested input divider
- cfg_fdiv  in  RATIO_W  requested feedback divider
- cfg_odiv  in  NUM_OUT*RATIO_W  output dividers; channel i at [i*RATIO_W +: RATIO_W]
- cfg_duty  in  NUM_OUT*RATIO_W  duty values, same packing
- cfg_phase  in  NUM_OUT*PHASE_W  phase values, same packing
- pll_lock  in  1  raw LOCK from the PLL (asynchronous)
- pll_rst_o  out  1  drives PLL RST
- dyn_idiv  out  RATIO_W  to RATIOI
- dyn_fdiv  out  RATIO_W  to RATIOF
- dyn_odiv  out  NUM_OUT*RATIO_W  to RATIO0..4
- dyn_duty  out  NUM_OUT*RATIO_W  to DUTY0..4
- dyn_phase  out  NUM_OUT*PHASE_W  to {CPHASEn,PHASEn}
- clkout_gate  out  NUM_OUT  to CLKOUTn_SYN; 1 = output running
- locked  out  1  qualified lock
- cfg_done  out  1  one-cycle pulse when a sequence completes
- cfg_err  out  1  one-cycle pulse on reject or FAULT entry
- busy  out  1  high in every state except IDLE and FAULT

Behaviour:
- Clock/reset: one clock (clkin1); rst is synchronous, active-high.
- Reset values:
  - pll_rst_o=1, clkout_gate=0, locked=0, cfg_ready=0, busy=1, cfg_done=0, cfg_err=0.
  - dyn_* = DEF_* values.
  - Retry count = 0.
  - State = RST_ASSERT. A power-up sequence runs with the defaults.
- pll_lock passes through a 2-flop synchroniser (2 cycles latency) before any use.
- States:
  - IDLE: cfg_ready=1. If cfg_valid is high, inputs are sampled in the same cycle.
    - Any idiv, fdiv, odiv or duty field equal to 0: cfg_err pulses, no other output changes, stay in IDLE.
    - Otherwise: latch all fields into dyn_* on the next edge, clear retry count, go to GATE_OFF.
  - GATE_OFF: clkout_gate=0, locked=0. Wait GATE_CYCLES, then go to RST_ASSERT.
  - RST_ASSERT: pll_rst_o=1 for RST_CYCLES, then release and go to LOCK_WAIT.
  - LOCK_WAIT: timeout counter runs.
    - Synchronised lock=1 → LOCK_QUAL.
    - Timeout expires → retry count +1. If count < MAX_RETRY go to RST_ASSERT; else go to FAULT.
  - LOCK_QUAL: stable counter runs and the timeout counter keeps running.
    - Lock drops → clear stable counter, return to LOCK_WAIT.
    - LOCK_STABLE consecutive highs → locked=1, clkout_gate=all 1s, cfg_done pulse, go to IDLE.
  - FAULT:
    - On entry: cfg_err pulses once.
    - While in FAULT: pll_rst_o=1, gates=0, locked=0, cfg_ready=1.
    - A valid cfg_valid behaves as in IDLE; an invalid one pulses cfg_err and stays in FAULT.
- cfg_valid while busy is ignored (cfg_ready=0). Requesters must hold cfg_valid until cfg_ready is high.
- Lock loss in IDLE (locked=1 and synchronised lock=0): locked and clkout_gate drop on the next cycle. Further handling depends on PLL_LOCK_WDOG_EN.
- rst mid-sequence: immediate return to the reset values. dyn_* revert to the defaults.
- Counter widths: $clog2(param+1). Counters do not wrap.

Optional Feature:
- Macro: PLL_LOCK_WDOG_EN.
- Defined:
  - Lock loss in IDLE automatically enters GATE_OFF, with dyn_* unchanged and the retry count cleared.
  - An 8-bit saturating relock_cnt output (extra port) increments on each auto-relock and clears on rst.
- Undefined:
  - Lock loss only drops locked and the gates. The controller stays in IDLE until a new request arrives.
  - No relock_cnt port.

Test Plan:
- Bench parameters: RST_CYCLES=8, LOCK_STABLE=16, LOCK_TIMEOUT=100, MAX_RETRY=2, GATE_CYCLES=4, NUM_OUT=5.
- Scenario 1 (power-up):
  - Stimulus: release rst; model raises lock 20 cycles after pll_rst_o falls.
  - Required: pll_rst_o high for 8 cycles; then, after lock rises, locked=1 and gates=5'b11111 once 2 sync cycles + 16 stable cycles have elapsed; cfg_done pulses once; dyn_idiv=2, dyn_fdiv=32.
- Scenario 2 (valid request):
  - Stimulus: from IDLE, request idiv=1, fdiv=30, odiv0=4.
  - Required: dyn_* update 1 cycle after the handshake; gates go to 0 the same cycle; pll_rst_o rises 4 cycles later; sequence completes with cfg_done.
- Scenario 3 (invalid request):
  - Stimulus: request with odiv2=0.
  - Required: cfg_err pulses 1 cycle; dyn_*, gates and locked unchanged; cfg_ready stays 1.
- Scenario 4 (lock never asserts):
  - Required: two 100-cycle timeouts, each followed by an 8-cycle reset; then FAULT with a cfg_err pulse, pll_rst_o held 1, cfg_ready=1. A subsequent valid request restarts the sequence.
- Scenario 5 (lock glitch):
  - Stimulus: lock high for 10 cycles, low for 1 cycle, then high.
  - Required: stable counter restarts; locked asserts only after 16 uninterrupted highs.
- Scenario 6 (lock loss in IDLE):
  - Stimulus: lock drops while in IDLE.
  - Required: locked and gates go low. With PLL_LOCK_WDOG_EN, a relock runs and relock_cnt=1; without it, the controller stays in IDLE.

Source files
------------

// File: rtl/pll_dyn_cfg_ctrl.sv
// pll_dyn_cfg_ctrl: dynamic reconfiguration sequencer for a GTP_PLL_E1 wrapper.
// Accepts a full ratio/duty/phase set over valid/ready, gates the outputs,
// drives the dynamic ports, pulses PLL reset, qualifies lock (with bounded
// retries) and re-enables the outputs. Everything runs on clkin1.
// Optional: define PLL_LOCK_WDOG_EN to auto-relock on lock loss in IDLE and
// expose an 8-bit saturating relock_cnt.
module pll_dyn_cfg_ctrl #(
  parameter int NUM_OUT      = 5,
  parameter int RATIO_W      = 10,
  parameter int PHASE_W      = 13,
  parameter int DEF_IDIV     = 2,
  parameter int DEF_FDIV     = 32,
  parameter int DEF_ODIV     = 8,
  parameter int DEF_PHASE    = 16,
  parameter int GATE_CYCLES  = 4,
  parameter int RST_CYCLES   = 64,
  parameter int LOCK_STABLE  = 1024,
  parameter int LOCK_TIMEOUT = 100000,
  parameter int MAX_RETRY    = 3
) (
  input  logic                       clkin1,
  input  logic                       rst,
  input  logic                       cfg_valid,
  output logic                       cfg_ready,
  input  logic [RATIO_W-1:0]         cfg_idiv,
  input  logic [RATIO_W-1:0]         cfg_fdiv,
  input  logic [NUM_OUT*RATIO_W-1:0] cfg_odiv,
  input  logic [NUM_OUT*RATIO_W-1:0] cfg_duty,
  input  logic [NUM_OUT*PHASE_W-1:0] cfg_phase,
  input  logic                       pll_lock,
  output logic                       pll_rst_o,
  output logic [RATIO_W-1:0]         dyn_idiv,
  output logic [RATIO_W-1:0]         dyn_fdiv,
  output logic [NUM_OUT*RATIO_W-1:0] dyn_odiv,
  output logic [NUM_OUT*RATIO_W-1:0] dyn_duty,
  output logic [NUM_OUT*PHASE_W-1:0] dyn_phase,
  output logic [NUM_OUT-1:0]         clkout_gate,
  output logic                       locked,
  output logic                       cfg_done,
  output logic                       cfg_err,
  output logic                       busy
`ifdef PLL_LOCK_WDOG_EN
  ,
  output logic [7:0]                 relock_cnt
`endif
);

  localparam int SEQ_MAX = (GATE_CYCLES > RST_CYCLES) ? GATE_CYCLES : RST_CYCLES;
  localparam int SEQ_W   = $clog2(SEQ_MAX + 1);
  localparam int TO_W    = $clog2(LOCK_TIMEOUT + 1);
  localparam int ST_W    = $clog2(LOCK_STABLE + 1);
  localparam int RTY_W   = $clog2(MAX_RETRY + 1);

  localparam logic [NUM_OUT*RATIO_W-1:0] DEF_ODIV_V  = {NUM_OUT{RATIO_W'(DEF_ODIV)}};
  localparam logic [NUM_OUT*PHASE_W-1:0] DEF_PHASE_V = {NUM_OUT{PHASE_W'(DEF_PHASE)}};

  typedef enum logic [2:0] {
    S_IDLE, S_GATE_OFF, S_RST_ASSERT, S_LOCK_WAIT, S_LOCK_QUAL, S_FAULT
  } state_t;

  state_t             state, state_nxt;
  logic [SEQ_W-1:0]   seq_cnt, seq_nxt;
  logic [TO_W-1:0]    to_cnt, to_nxt, to_inc;
  logic [ST_W-1:0]    st_cnt, st_nxt;
  logic [RTY_W-1:0]   retry, rty_nxt, rty_inc;
  logic [NUM_OUT-1:0] gate_q, gate_nxt;
  logic               locked_q, locked_nxt;
  logic               done_q, done_nxt, err_q, err_nxt;
  logic               load, tmo, to_hit;
  logic [1:0]         lock_sync;
  logic               lock_s;
  logic [NUM_OUT-1:0] ch_zero;
  logic               cfg_bad;
`ifdef PLL_LOCK_WDOG_EN
  logic               relock_inc;
`endif

  // A zero divider or duty on any channel makes the whole request unusable
  for (genvar i = 0; i < NUM_OUT; i++) begin : g_chk
    assign ch_zero[i] = (cfg_odiv[i*RATIO_W +: RATIO_W] == '0) ||
                        (cfg_duty[i*RATIO_W +: RATIO_W] == '0);
  end
  assign cfg_bad = (cfg_idiv == '0) || (cfg_fdiv == '0) || (|ch_zero);

  // Two-flop synchroniser for the asynchronous PLL LOCK
  always_ff @(posedge clkin1) begin
    if (rst) lock_sync <= '0;
    else     lock_sync <= {lock_sync[0], pll_lock};
  end
  assign lock_s = lock_sync[1];

  assign to_hit  = (to_cnt >= TO_W'(LOCK_TIMEOUT - 1));
  assign to_inc  = to_hit ? to_cnt : to_cnt + TO_W'(1);
  assign rty_inc = retry + RTY_W'(1);

  // Next-state and next-output decode
  always_comb begin
    state_nxt  = state;
    seq_nxt    = seq_cnt;
    to_nxt     = to_cnt;
    st_nxt     = st_cnt;
    rty_nxt    = retry;
    gate_nxt   = gate_q;
    locked_nxt = locked_q;
    done_nxt   = 1'b0;
    err_nxt    = 1'b0;
    load       = 1'b0;
    tmo        = 1'b0;
`ifdef PLL_LOCK_WDOG_EN
    relock_inc = 1'b0;
`endif
    case (state)
      S_IDLE, S_FAULT: begin
        if (state == S_IDLE && locked_q && !lock_s) begin
          gate_nxt   = '0;
          locked_nxt = 1'b0;
`ifdef PLL_LOCK_WDOG_EN
          state_nxt  = S_GATE_OFF;
          seq_nxt    = '0;
          rty_nxt    = '0;
          relock_inc = 1'b1;
`endif
        end
        if (cfg_valid) begin
          if (cfg_bad) begin
            err_nxt = 1'b1;
          end else begin
            load       = 1'b1;
            rty_nxt    = '0;
            seq_nxt    = '0;
            gate_nxt   = '0;
            locked_nxt = 1'b0;
            state_nxt  = S_GATE_OFF;
`ifdef PLL_LOCK_WDOG_EN
            relock_inc = 1'b0;
`endif
          end
        end
      end
      S_GATE_OFF: begin
        gate_nxt   = '0;
        locked_nxt = 1'b0;
        if (seq_cnt == SEQ_W'(GATE_CYCLES - 1)) begin
          seq_nxt   = '0;
          state_nxt = S_RST_ASSERT;
        end else begin
          seq_nxt = seq_cnt + SEQ_W'(1);
        end
      end
      S_RST_ASSERT: begin
        if (seq_cnt == SEQ_W'(RST_CYCLES - 1)) begin
          seq_nxt   = '0;
          to_nxt    = '0;
          st_nxt    = '0;
          state_nxt = S_LOCK_WAIT;
        end else begin
          seq_nxt = seq_cnt + SEQ_W'(1);
        end
      end
      S_LOCK_WAIT: begin
        if (lock_s) begin
          st_nxt    = ST_W'(1);
          to_nxt    = to_inc;
          state_nxt = S_LOCK_QUAL;
        end else if (to_hit) begin
          tmo = 1'b1;
        end else begin
          to_nxt = to_inc;
        end
      end
      S_LOCK_QUAL: begin
        if (lock_s && st_cnt >= ST_W'(LOCK_STABLE - 1)) begin
          st_nxt     = '0;
          locked_nxt = 1'b1;
          gate_nxt   = '1;
          done_nxt   = 1'b1;
          state_nxt  = S_IDLE;
        end else if (to_hit) begin
          tmo = 1'b1;
        end else if (!lock_s) begin
          st_nxt    = '0;
          to_nxt    = to_inc;
          state_nxt = S_LOCK_WAIT;
        end else begin
          st_nxt = st_cnt + ST_W'(1);
          to_nxt = to_inc;
        end
      end
      default: state_nxt = S_FAULT;
    endcase
    // An expired lock attempt either retries the reset or gives up
    if (tmo) begin
      rty_nxt = rty_inc;
      seq_nxt = '0;
      st_nxt  = '0;
      if (rty_inc < RTY_W'(MAX_RETRY)) begin
        state_nxt = S_RST_ASSERT;
      end else begin
        state_nxt = S_FAULT;
        err_nxt   = 1'b1;
      end
    end
  end

  // Sequencer state and status registers
  always_ff @(posedge clkin1) begin
    if (rst) begin
      state    <= S_RST_ASSERT;
      seq_cnt  <= '0;
      to_cnt   <= '0;
      st_cnt   <= '0;
      retry    <= '0;
      gate_q   <= '0;
      locked_q <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      seq_cnt  <= seq_nxt;
      to_cnt   <= to_nxt;
      st_cnt   <= st_nxt;
      retry    <= rty_nxt;
      gate_q   <= gate_nxt;
      locked_q <= locked_nxt;
      done_q   <= done_nxt;
      err_q    <= err_nxt;
    end
  end

  // Dynamic port shadow: defaults after reset, request fields on accept
  always_ff @(posedge clkin1) begin
    if (rst) begin
      dyn_idiv  <= RATIO_W'(DEF_IDIV);
      dyn_fdiv  <= RATIO_W'(DEF_FDIV);
      dyn_odiv  <= DEF_ODIV_V;
      dyn_duty  <= DEF_ODIV_V;
      dyn_phase <= DEF_PHASE_V;
    end else if (load) begin
      dyn_idiv  <= cfg_idiv;
      dyn_fdiv  <= cfg_fdiv;
      dyn_odiv  <= cfg_odiv;
      dyn_duty  <= cfg_duty;
      dyn_phase <= cfg_phase;
    end
  end

`ifdef PLL_LOCK_WDOG_EN
  // Saturating count of automatic relocks
  always_ff @(posedge clkin1) begin
    if (rst)                                relock_cnt <= '0;
    else if (relock_inc && relock_cnt != 8'hFF) relock_cnt <= relock_cnt + 8'd1;
  end
`endif

  assign cfg_ready   = (state == S_IDLE) || (state == S_FAULT);
  assign busy        = !cfg_ready;
  assign pll_rst_o   = (state == S_RST_ASSERT) || (state == S_FAULT);
  assign clkout_gate = gate_q;
  assign locked      = locked_q;
  assign cfg_done    = done_q;
  assign cfg_err     = err_q;

endmodule

// File: tb/tb_pll_dyn_cfg_ctrl.sv
// Self-checking bench for pll_dyn_cfg_ctrl. Expected done/err events are
// queued when a request is driven and compared when the DUT pulses.
module tb_pll_dyn_cfg_ctrl;
  localparam int NO = 5;
  localparam int RW = 10;
  localparam int PW = 13;

  typedef struct {
    logic [RW-1:0]    idiv;
    logic [RW-1:0]    fdiv;
    logic [NO*RW-1:0] odiv;
    logic [NO*RW-1:0] duty;
    logic [NO*PW-1:0] phase;
  } cfg_t;

  typedef struct {
    bit            is_err;
    cfg_t          c;
    logic [NO-1:0] gate;
    logic          lck;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst, cfg_valid, cfg_ready, pll_lock, pll_rst_o, locked, cfg_done, cfg_err, busy;
  logic [RW-1:0] cfg_idiv, cfg_fdiv, dyn_idiv, dyn_fdiv;
  logic [NO*RW-1:0] cfg_odiv, cfg_duty, dyn_odiv, dyn_duty;
  logic [NO*PW-1:0] cfg_phase, dyn_phase;
  logic [NO-1:0] clkout_gate;
`ifdef PLL_LOCK_WDOG_EN
  logic [7:0] relock_cnt;
`endif

  pll_dyn_cfg_ctrl #(
    .NUM_OUT(NO), .RATIO_W(RW), .PHASE_W(PW), .GATE_CYCLES(4), .RST_CYCLES(8),
    .LOCK_STABLE(16), .LOCK_TIMEOUT(100), .MAX_RETRY(2)
  ) dut (
    .clkin1(clk), .rst(rst), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .cfg_idiv(cfg_idiv), .cfg_fdiv(cfg_fdiv), .cfg_odiv(cfg_odiv), .cfg_duty(cfg_duty),
    .cfg_phase(cfg_phase), .pll_lock(pll_lock), .pll_rst_o(pll_rst_o),
    .dyn_idiv(dyn_idiv), .dyn_fdiv(dyn_fdiv), .dyn_odiv(dyn_odiv), .dyn_duty(dyn_duty),
    .dyn_phase(dyn_phase), .clkout_gate(clkout_gate), .locked(locked),
    .cfg_done(cfg_done), .cfg_err(cfg_err), .busy(busy)
`ifdef PLL_LOCK_WDOG_EN
    , .relock_cnt(relock_cnt)
`endif
  );

  int   vec_cnt = 0;
  int   err_cnt = 0;
  int   cyc = 0;
  bit   auto_lock = 1'b1;
  int   lock_delay = 20;
  int   since = 0;
  int   rise_cyc = 0;
  exp_t sbq[$];
  exp_t m_e;
  cfg_t cur, defc;

  function automatic exp_t mk_exp(bit e, cfg_t c, logic [NO-1:0] g, logic l);
    exp_t x;
    x.is_err = e; x.c = c; x.gate = g; x.lck = l;
    return x;
  endfunction

  function automatic logic [NO*RW+NO*RW+NO*PW+2*RW-1:0] cat(cfg_t c);
    return {c.idiv, c.fdiv, c.odiv, c.duty, c.phase};
  endfunction

  // Scoreboard: every done/err pulse must match the oldest queued expectation
  always @(negedge clk) begin
    if (cfg_done === 1'b1 || cfg_err === 1'b1) begin
      vec_cnt++;
      if (sbq.size() == 0) begin
        err_cnt++;
        $display("FAIL sb_unexpected: got done=%b err=%b, expected no event", cfg_done, cfg_err);
      end else begin
        m_e = sbq.pop_front();
        if (cfg_err !== m_e.is_err) begin
          err_cnt++;
          $display("FAIL sb_kind: got err=%b, expected err=%b", cfg_err, m_e.is_err);
        end
        vec_cnt++;
        if ({dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase} !== cat(m_e.c)) begin
          err_cnt++;
          $display("FAIL sb_dyn: got %h expected %h",
                   {dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase}, cat(m_e.c));
        end
        vec_cnt++;
        if ({clkout_gate, locked} !== {m_e.gate, m_e.lck}) begin
          err_cnt++;
          $display("FAIL sb_status: got gate=%b locked=%b expected gate=%b locked=%b",
                   clkout_gate, locked, m_e.gate, m_e.lck);
        end
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  // One cycle; lock model raises LOCK lock_delay cycles after pll_rst_o falls
  task automatic step();
    @(negedge clk);
    cyc++;
    if (auto_lock) begin
      if (pll_rst_o) begin
        since = 0; pll_lock = 1'b0;
      end else begin
        since++;
        if (since >= lock_delay && !pll_lock) begin
          pll_lock = 1'b1; rise_cyc = cyc;
        end
      end
    end
  endtask

  task automatic drive(cfg_t c);
    cfg_idiv = c.idiv; cfg_fdiv = c.fdiv; cfg_odiv = c.odiv;
    cfg_duty = c.duty; cfg_phase = c.phase;
  endtask

  // Present a request until accepted; returns at the negedge after the accept edge
  task automatic handshake(cfg_t c);
    int n;
    n = 0;
    drive(c);
    cfg_valid = 1'b1;
    while (!cfg_ready && n < 2000) begin step(); n++; end
    if (n >= 2000) begin
      vec_cnt++; err_cnt++;
      $display("FAIL hs_timeout: cfg_ready=%b, expected 1", cfg_ready);
    end
    step();
    cfg_valid = 1'b0;
  endtask

  task automatic wait_event(string nm);
    int n;
    n = 0;
    while (cfg_done !== 1'b1 && cfg_err !== 1'b1 && n < 3000) begin step(); n++; end
    if (n >= 3000) begin
      vec_cnt++; err_cnt++;
      $display("FAIL %s_timeout: no done/err pulse, expected one", nm);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; cfg_valid = 1'b0; pll_lock = 1'b0; auto_lock = 1'b1;
    drive(defc);
    repeat (3) step();
    vec_cnt++;
    if ({pll_rst_o, clkout_gate, locked, cfg_ready, busy, cfg_done, cfg_err} !== 11'b1_00000_0_0_1_0_0) begin
      err_cnt++;
      $display("FAIL rst_ctrl: got %b, expected %b",
               {pll_rst_o, clkout_gate, locked, cfg_ready, busy, cfg_done, cfg_err}, 11'b1_00000_0_0_1_0_0);
    end
    vec_cnt++;
    if ({dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase} !== cat(defc)) begin
      err_cnt++;
      $display("FAIL rst_dyn: got %h expected %h", {dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase}, cat(defc));
    end
  endtask

  task automatic test_powerup();
    int n;
    sbq.push_back(mk_exp(1'b0, defc, 5'b11111, 1'b1));
    rst = 1'b0;
    n = 0;
    while (pll_rst_o && n < 50) begin n++; step(); end
    vec_cnt++;
    if (n != 8) begin err_cnt++; $display("FAIL pwr_rst_len: got %0d cycles, expected 8", n); end
    n = 0;
    while (!locked && n < 300) begin step(); n++; end
    vec_cnt++;
    if (cyc - rise_cyc != 18) begin
      err_cnt++; $display("FAIL pwr_lock_lat: got %0d cycles, expected 18", cyc - rise_cyc);
    end
    vec_cnt++;
    if (cfg_done !== 1'b1) begin err_cnt++; $display("FAIL pwr_done: got %b expected 1", cfg_done); end
    step();
    vec_cnt++;
    if ({cfg_done, cfg_ready, busy} !== 3'b010) begin
      err_cnt++; $display("FAIL pwr_idle: got done/ready/busy=%b expected 010", {cfg_done, cfg_ready, busy});
    end
    cur = defc;
  endtask

  task automatic test_valid_req();
    cfg_t c;
    int n;
    c.idiv = 10'd1; c.fdiv = 10'd30;
    c.odiv = {10'd12, 10'd10, 10'd8, 10'd6, 10'd4};
    c.duty = {10'd11, 10'd9, 10'd7, 10'd5, 10'd3};
    c.phase = {13'd40, 13'd30, 13'd20, 13'd10, 13'd0};
    sbq.push_back(mk_exp(1'b0, c, 5'b11111, 1'b1));
    handshake(c);
    vec_cnt++;
    if ({dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase} !== cat(c)) begin
      err_cnt++; $display("FAIL req_dyn: got %h expected %h", {dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase}, cat(c));
    end
    vec_cnt++;
    if ({clkout_gate, locked, cfg_ready} !== 7'b0) begin
      err_cnt++; $display("FAIL req_gate: got gate/locked/ready=%b expected 0", {clkout_gate, locked, cfg_ready});
    end
    n = 0;
    while (!pll_rst_o && n < 20) begin step(); n++; end
    vec_cnt++;
    if (n != 4) begin err_cnt++; $display("FAIL req_gate_len: got %0d expected 4", n); end
    wait_event("req");
    cur = c;
    step();
  endtask

  task automatic test_invalid_req();
    cfg_t b;
    for (int k = 0; k < 3; k++) begin
      b = cur;
      if (k == 0) b.odiv[2*RW +: RW] = '0;
      if (k == 1) b.duty[4*RW +: RW] = '0;
      if (k == 2) b.idiv = '0;
      sbq.push_back(mk_exp(1'b1, cur, 5'b11111, 1'b1));
      drive(b); cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      vec_cnt++;
      if ({cfg_err, cfg_ready} !== 2'b11) begin
        err_cnt++; $display("FAIL bad%0d_err: got err/ready=%b expected 11", k, {cfg_err, cfg_ready});
      end
      step();
      vec_cnt++;
      if ({cfg_err, cfg_ready, busy} !== 3'b010) begin
        err_cnt++; $display("FAIL bad%0d_after: got err/ready/busy=%b expected 010", k, {cfg_err, cfg_ready, busy});
      end
    end
  endtask

  task automatic test_lock_glitch();
    cfg_t c;
    int n, r2;
    bit early;
    c = cur; c.fdiv = 10'd40; c.phase[PW-1:0] = 13'd7;
    auto_lock = 1'b0; pll_lock = 1'b0;
    sbq.push_back(mk_exp(1'b0, c, 5'b11111, 1'b1));
    handshake(c);
    n = 0;
    while (!pll_rst_o && n < 50) begin step(); n++; end
    while (pll_rst_o && n < 100) begin step(); n++; end
    repeat (20) step();
    pll_lock = 1'b1;
    early = 1'b0;
    repeat (10) begin step(); if (locked) early = 1'b1; end
    pll_lock = 1'b0;
    step(); if (locked) early = 1'b1;
    pll_lock = 1'b1; r2 = cyc;
    n = 0;
    while (!locked && n < 200) begin step(); n++; end
    vec_cnt++;
    if (early || cyc - r2 != 18) begin
      err_cnt++; $display("FAIL glitch_lat: got %0d cycles early=%b, expected 18 early=0", cyc - r2, early);
    end
    cur = c;
    step();
  endtask

  task automatic test_lock_timeout();
    cfg_t c, d;
    int run[4];
    c = cur; c.idiv = 10'd3; c.odiv[RW-1:0] = 10'd5;
    d = cur; d.fdiv = 10'd50;
    auto_lock = 1'b0; pll_lock = 1'b0;
    sbq.push_back(mk_exp(1'b1, c, 5'b00000, 1'b0));
    handshake(c);
    for (int k = 0; k < 500 && !pll_rst_o; k++) step();
    for (int p = 0; p < 4; p++) begin
      run[p] = 0;
      while (pll_rst_o == (p % 2 == 0) && run[p] < 500) begin step(); run[p]++; end
    end
    vec_cnt++;
    if (run[0] != 8 || run[1] != 100 || run[2] != 8 || run[3] != 100) begin
      err_cnt++; $display("FAIL tmo_runs: got %0d/%0d/%0d/%0d expected 8/100/8/100", run[0], run[1], run[2], run[3]);
    end
    vec_cnt++;
    if ({cfg_err, cfg_ready, busy} !== 3'b110) begin
      err_cnt++; $display("FAIL tmo_fault: got err/ready/busy=%b expected 110", {cfg_err, cfg_ready, busy});
    end
    repeat (10) step();
    vec_cnt++;
    if ({pll_rst_o, cfg_ready, cfg_err, clkout_gate, locked} !== {3'b110, 6'b0}) begin
      err_cnt++; $display("FAIL tmo_hold: got %b expected %b", {pll_rst_o, cfg_ready, cfg_err, clkout_gate, locked}, {3'b110, 6'b0});
    end
    sbq.push_back(mk_exp(1'b1, c, 5'b00000, 1'b0));
    d.idiv = '0; drive(d); cfg_valid = 1'b1;
    step(); cfg_valid = 1'b0; step();
    vec_cnt++;
    if ({pll_rst_o, cfg_ready, busy} !== 3'b110) begin
      err_cnt++; $display("FAIL fault_bad: got rst/ready/busy=%b expected 110", {pll_rst_o, cfg_ready, busy});
    end
    d.idiv = 10'd4;
    auto_lock = 1'b1; since = 0;
    sbq.push_back(mk_exp(1'b0, d, 5'b11111, 1'b1));
    handshake(d);
    vec_cnt++;
    if (busy !== 1'b1) begin err_cnt++; $display("FAIL fault_restart: got busy=%b expected 1", busy); end
    wait_event("restart");
    cur = d;
    step();
  endtask

  task automatic test_mid_reset();
    cfg_t c;
    c = cur; c.odiv[3*RW +: RW] = 10'd9;
    handshake(c);
    repeat (6) step();
    rst = 1'b1;
    step();
    vec_cnt++;
    if ({dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase} !== cat(defc)) begin
      err_cnt++; $display("FAIL mid_dyn: got %h expected %h", {dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase}, cat(defc));
    end
    vec_cnt++;
    if ({pll_rst_o, cfg_ready, busy, clkout_gate, locked} !== {3'b101, 6'b0}) begin
      err_cnt++; $display("FAIL mid_ctrl: got %b expected %b", {pll_rst_o, cfg_ready, busy, clkout_gate, locked}, {3'b101, 6'b0});
    end
    sbq.push_back(mk_exp(1'b0, defc, 5'b11111, 1'b1));
    rst = 1'b0;
    wait_event("mid");
    cur = defc;
    step();
  endtask

  task automatic test_lock_loss();
    int l, n;
    auto_lock = 1'b0; pll_lock = 1'b0; l = cyc;
    n = 0;
    while (locked && n < 20) begin step(); n++; end
    vec_cnt++;
    if (cyc - l != 3 || clkout_gate !== 5'b0) begin
      err_cnt++; $display("FAIL loss_drop: got %0d cycles gate=%b, expected 3 gate=00000", cyc - l, clkout_gate);
    end
`ifdef PLL_LOCK_WDOG_EN
    vec_cnt++;
    if (busy !== 1'b1) begin err_cnt++; $display("FAIL loss_relock: got busy=%b expected 1", busy); end
    sbq.push_back(mk_exp(1'b0, cur, 5'b11111, 1'b1));
    auto_lock = 1'b1; since = 0;
    wait_event("relock");
    vec_cnt++;
    if (relock_cnt !== 8'd1) begin err_cnt++; $display("FAIL relock_cnt: got %0d expected 1", relock_cnt); end
`else
    repeat (20) step();
    vec_cnt++;
    if ({cfg_ready, busy, pll_rst_o, locked, clkout_gate} !== {4'b1000, 5'b0}) begin
      err_cnt++; $display("FAIL loss_idle: got %b expected %b", {cfg_ready, busy, pll_rst_o, locked, clkout_gate}, {4'b1000, 5'b0});
    end
    vec_cnt++;
    if ({dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase} !== cat(cur)) begin
      err_cnt++; $display("FAIL loss_dyn: got %h expected %h", {dyn_idiv, dyn_fdiv, dyn_odiv, dyn_duty, dyn_phase}, cat(cur));
    end
`endif
  endtask

  initial begin
    defc.idiv = 10'd2; defc.fdiv = 10'd32;
    defc.odiv = {NO{10'd8}}; defc.duty = {NO{10'd8}}; defc.phase = {NO{13'd16}};
    cur = defc;
    test_reset();
    test_powerup();
    test_valid_req();
    test_invalid_req();
    test_lock_glitch();
    test_lock_timeout();
    test_mid_reset();
    test_lock_loss();
    step();
    vec_cnt++;
    if (sbq.size() != 0) begin
      err_cnt++; $display("FAIL sb_leftover: got %0d pending, expected 0", sbq.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end
endmodule
